// File: rtl/nbit_demux_ctrl_pkg.sv
// Shared encodings for the 1-to-2 word router: drain FSM states and route select values.
package nbit_demux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // inSel value per destination; also used as the index of that output's queue.
  localparam logic ROUTE_FIRST  = 1'b1;
  localparam logic ROUTE_SECOND = 1'b0;

endpackage

// File: rtl/nbit_sync_fifo.sv
// Small synchronous FIFO with a registered head word. The head register keeps the
// last popped word when the queue runs empty, so the consumer-facing data never glitches.
module nbit_sync_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array; contents only matter where count says they are valid, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= din;
  end

  // Pointers, occupancy and head register. Pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      head  <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Next head comes from storage if a second word exists, else from the incoming word.
      if (do_pop && count > CW'(1))
        head <= mem[rptr + AW'(1)];
      else if (do_push && (empty || (do_pop && count == CW'(1))))
        head <= din;
    end
  end

endmodule

// File: rtl/nbit_demux_ctrl.sv
// Handshaked 1-to-2 router. Each accepted word is queued for the output picked by inSel;
// a drain FSM can stop intake and report once both queues have emptied.
module nbit_demux_ctrl
  import nbit_demux_ctrl_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inValid,
  output logic          inReady,
  input  logic [N-1:0]  inData,
  input  logic          inSel,
  output logic          firstValid,
  input  logic          firstReady,
  output logic [N-1:0]  firstData,
  output logic          secondValid,
  input  logic          secondReady,
  output logic [N-1:0]  secondData,
  input  logic          flush,
  input  logic          drainReq,
  output logic          drainDone,
  output logic [CW-1:0] firstCount,
  output logic [CW-1:0] secondCount
);

  state_e               state, state_nxt;
  logic                 accept;
  logic [1:0]           push, pop, full, empty, rdy;
  logic [1:0][N-1:0]    head;
  logic [1:0][CW-1:0]   cnt;

  // Queue index equals the inSel route value: [1] = first, [0] = second.
  assign rdy    = {firstReady, secondReady};
  assign accept = inValid & inReady;

  for (genvar g = 0; g < 2; g++) begin : g_q
    assign push[g] = accept & (inSel == 1'(g));
    assign pop[g]  = rdy[g] & ~empty[g];
    nbit_sync_fifo #(.N(N), .DEPTH(DEPTH), .CW(CW)) u_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .clear (flush),
      .din   (inData),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .count (cnt[g])
    );
  end

  assign firstValid  = ~empty[ROUTE_FIRST];
  assign firstData   = head[ROUTE_FIRST];
  assign firstCount  = cnt[ROUTE_FIRST];
  assign secondValid = ~empty[ROUTE_SECOND];
  assign secondData  = head[ROUTE_SECOND];
  assign secondCount = cnt[ROUTE_SECOND];

  // Drain FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Drain FSM transitions; requests outside RUN are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (drainReq) state_nxt = ST_DRAIN;
      ST_DRAIN: if (flush || (empty[0] && empty[1])) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Intake gating and drain completion pulse, both decoded from registered state.
  always_comb begin
    inReady   = (state == ST_RUN) & ~flush & ~full[inSel];
    drainDone = (state == ST_DONE);
  end

endmodule

// File: tb/tb_nbit_demux_ctrl.sv
// Bench for nbit_demux_ctrl: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the two outputs and the drain sequence.
module tb_nbit_demux_ctrl;

  localparam int N = 32, DEPTH = 2, CW = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          inValid = 1'b0, inSel = 1'b0, inReady;
  logic [N-1:0]  inData = '0;
  logic          firstValid, firstReady = 1'b0, secondValid, secondReady = 1'b0;
  logic [N-1:0]  firstData, secondData;
  logic          flush = 1'b0, drainReq = 1'b0, drainDone;
  logic [CW-1:0] firstCount, secondCount;

  always #5 clk = ~clk;

  nbit_demux_ctrl #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady), .inData(inData), .inSel(inSel),
    .firstValid(firstValid), .firstReady(firstReady), .firstData(firstData),
    .secondValid(secondValid), .secondReady(secondReady), .secondData(secondData),
    .flush(flush), .drainReq(drainReq), .drainDone(drainDone),
    .firstCount(firstCount), .secondCount(secondCount)
  );

  int vectors = 0, miscompares = 0;

  // Reference model: one expected-word queue per output ([1]=first, [0]=second),
  // last popped word per output, and the drain phase (0=running, 1=draining, 2=done pulse).
  logic [N-1:0]        mq [2][$];
  logic [N-1:0]        last [2];
  bit                  lastok [2];
  int                  mode = 0;
  string               pfx [2] = '{"second", "first"};

  logic [1:0]          v, r;
  logic [1:0][N-1:0]   d;
  logic [1:0][CW-1:0]  c;
  bit                  er, emp;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compare outputs mid-cycle, then advance the model by what the
  // coming clock edge will do with the handshakes currently on the wires.
  always @(negedge clk) begin
    v = {firstValid, secondValid};
    r = {firstReady, secondReady};
    d = {firstData, secondData};
    c = {firstCount, secondCount};
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        last[i]   = '0;
        lastok[i] = 1'b1;
        chk({pfx[i], "CountRst"}, 32'(c[i]), 32'd0);
        chk({pfx[i], "ValidRst"}, 32'(v[i]), 32'd0);
      end
      chk("drainDoneRst", 32'(drainDone), 32'd0);
      mode = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk({pfx[i], "Count"}, 32'(c[i]), 32'(mq[i].size()));
        chk({pfx[i], "Valid"}, 32'(v[i]), 32'(mq[i].size() > 0));
        if (mq[i].size() > 0)  chk({pfx[i], "Data"}, d[i], mq[i][0]);
        else if (lastok[i])    chk({pfx[i], "DataHold"}, d[i], last[i]);
      end
      er = (mode == 0) && !flush && (mq[int'(inSel)].size() < DEPTH);
      chk("inReady", 32'(inReady), 32'(er));
      chk("drainDone", 32'(drainDone), 32'(mode == 2));
      emp = (mq[0].size() == 0) && (mq[1].size() == 0);
      if (flush) begin
        for (int i = 0; i < 2; i++) begin
          mq[i].delete();
          lastok[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++)
          if (v[i] && r[i] && mq[i].size() > 0) begin
            last[i]   = mq[i].pop_front();
            lastok[i] = 1'b1;
          end
        if (inValid && er) mq[int'(inSel)].push_back(inData);
      end
      case (mode)
        0:       if (drainReq) mode = 1;
        1:       if (flush || emp) mode = 2;
        default: mode = 0;
      endcase
    end
  end

  task automatic step(bit vi, bit s, logic [31:0] dat, bit fr, bit sr, bit fl, bit dr);
    inValid = vi; inSel = s; inData = dat;
    firstReady = fr; secondReady = sr; flush = fl; drainReq = dr;
    @(posedge clk); #1;
  endtask

  task automatic idle(int n, bit fr, bit sr);
    repeat (n) step(1'b0, 1'b0, 32'h0, fr, sr, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset with two words queued on first
    step(1, 1, 32'h1111_0001, 0, 0, 0, 0);
    step(1, 1, 32'h1111_0002, 0, 0, 0, 0);
    rst_n = 1'b0;
    idle(2, 1, 1);
    rst_n = 1'b1;
    idle(1, 0, 0);

    // Routing polarity and one-cycle latency
    step(1, 1, 32'hA5A5_0001, 1, 1, 0, 0);
    step(1, 0, 32'h0000_0002, 1, 1, 0, 0);
    idle(2, 1, 1);

    // Backpressure on first; second still accepts
    step(1, 1, 32'hB0B0_0001, 0, 0, 0, 0);
    step(1, 1, 32'hB0B0_0002, 0, 0, 0, 0);
    step(1, 1, 32'hB0B0_0003, 0, 0, 0, 0);
    step(1, 0, 32'hB0B0_0004, 0, 0, 0, 0);
    idle(1, 0, 0);
    idle(3, 1, 1);

    // Simultaneous push/pop at count 1, pointer wrap over five words
    for (int k = 1; k <= 5; k++) step(1, 1, 32'hC000_0000 + k, 1, 0, 0, 0);
    idle(2, 1, 1);

    // Drain with counts 2/1, intake attempts refused while draining
    step(1, 1, 32'hD000_0001, 0, 0, 0, 0);
    step(1, 1, 32'hD000_0002, 0, 0, 0, 0);
    step(1, 0, 32'hD000_0003, 0, 0, 0, 0);
    step(0, 0, 32'h0, 1, 1, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 1'($urandom), $urandom, 1, 1, 0, 0);
    // Drain with empty queues
    step(0, 0, 32'h0, 1, 1, 0, 1);
    idle(4, 1, 1);

    // Flush with a word offered in the same cycle
    step(1, 1, 32'hE000_0001, 0, 0, 0, 0);
    step(1, 0, 32'hE000_0002, 0, 0, 0, 0);
    step(1, 1, 32'hE000_0003, 0, 0, 1, 0);
    idle(2, 0, 0);
    // Flush during drain
    step(1, 1, 32'hF000_0001, 0, 0, 0, 0);
    step(1, 1, 32'hF000_0002, 0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1, 0);
    idle(3, 0, 0);

    // Random traffic
    repeat (800)
      step(($urandom % 4) != 0, 1'($urandom), $urandom, ($urandom % 4) != 0,
           ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 25) == 0);
    idle(4, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
